// File: rtl/calc_port_responder.sv
// calc_port_responder: responder end of one calculator2 port.
// A request is two cycles long. The command, operand 1 and the tag arrive
// first, and operand 2 arrives in the next cycle. The result is computed when
// operand 2 is captured. It then travels through a LATENCY-deep pipeline and
// is presented for exactly one cycle.
//
// Handshake: the request side has no ready signal. A nonzero req_cmd_in seen
// in IDLE is always accepted, and the next cycle is always taken as operand 2.
// The response side has no backpressure. out_resp != 0 marks a valid response
// for exactly one cycle, together with out_data and out_tag.
module calc_port_responder #(
    parameter int LATENCY = 3
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic [3:0]  req_cmd_in,
    input  logic [31:0] req_data_in,
    input  logic [1:0]  req_tag_in,
    output logic [1:0]  out_resp,
    output logic [31:0] out_data,
    output logic [1:0]  out_tag,
    output logic        proto_err,
    output logic        dbg_state
);

    localparam logic [1:0] RESP_OK  = 2'd1;
    localparam logic [1:0] RESP_ERR = 2'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OP2  = 1'b1
    } state_t;

    // owner marks the entry that set its tag bit. Only that entry may clear
    // the bit, so a conflicting duplicate never releases someone else's tag.
    typedef struct packed {
        logic        valid;
        logic        owner;
        logic [1:0]  resp;
        logic [31:0] data;
        logic [1:0]  tag;
    } entry_t;

    state_t      state_q, state_d;
    logic [3:0]  cmd_q;
    logic [31:0] op1_q;
    logic [1:0]  tag_q;
    logic        capture;
    logic        launch;
    logic        proto_d;

    entry_t      pipe_q [LATENCY];
    entry_t      new_entry;
    entry_t      retire;

    logic [3:0]  busy_q, busy_d, busy_cleared;
    logic        conflict;
    logic [1:0]  calc_resp;
    logic [31:0] calc_data;
    logic [32:0] sum;

    assign dbg_state = state_q;
    assign retire    = pipe_q[LATENCY-1];

    // Capture FSM: the register process.
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Capture FSM: next state and the capture, launch and protocol-error
    // strobes.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        launch  = 1'b0;
        proto_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_cmd_in != 4'd0) begin
                    capture = 1'b1;
                    state_d = ST_OP2;
                end
            end
            ST_OP2: begin
                // Always taken as operand 2. A command seen here is only
                // flagged as a protocol error.
                launch  = 1'b1;
                proto_d = (req_cmd_in != 4'd0);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Latch the command, operand 1 and the tag in the command cycle.
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            cmd_q <= 4'd0;
            op1_q <= 32'd0;
            tag_q <= 2'd0;
        end else if (capture) begin
            cmd_q <= req_cmd_in;
            op1_q <= req_data_in;
            tag_q <= req_tag_in;
        end
    end

    // Compute the result from the latched operand 1 and the live operand 2.
    always_comb begin
        sum       = {1'b0, op1_q} + {1'b0, req_data_in};
        calc_resp = RESP_ERR;
        calc_data = 32'd0;
        case (cmd_q)
            4'd1: begin
                if (!sum[32]) begin
                    calc_resp = RESP_OK;
                    calc_data = sum[31:0];
                end
            end
            4'd2: begin
                if (req_data_in <= op1_q) begin
                    calc_resp = RESP_OK;
                    calc_data = op1_q - req_data_in;
                end
            end
            4'd5: begin
                calc_resp = RESP_OK;
                calc_data = op1_q << req_data_in[4:0];
            end
            4'd6: begin
                calc_resp = RESP_OK;
                calc_data = op1_q >> req_data_in[4:0];
            end
            default: begin
                calc_resp = RESP_ERR;
                calc_data = 32'd0;
            end
        endcase
    end

    // Tag bitmap update. A retiring owner's clear is applied first, so a tag
    // freed on this edge can be reused by the request launching on this edge.
    always_comb begin
        busy_cleared = busy_q;
        if (retire.valid && retire.owner) busy_cleared[retire.tag] = 1'b0;
        conflict = busy_cleared[tag_q];
        busy_d   = busy_cleared;
        if (launch && !conflict) busy_d[tag_q] = 1'b1;

        new_entry = '0;
        if (launch) begin
            new_entry.valid = 1'b1;
            new_entry.owner = !conflict;
            new_entry.resp  = conflict ? RESP_ERR : calc_resp;
            new_entry.data  = conflict ? 32'd0 : calc_data;
            new_entry.tag   = tag_q;
        end
    end

    // Latency pipeline and bitmap. A reset drops every in-flight entry.
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            busy_q <= 4'd0;
            for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
        end else begin
            busy_q    <= busy_d;
            pipe_q[0] <= new_entry;
            for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    // Registered response outputs and the protocol-error pulse. The outputs
    // are zero in every cycle in which no entry retires.
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            out_resp  <= 2'd0;
            out_data  <= 32'd0;
            out_tag   <= 2'd0;
            proto_err <= 1'b0;
        end else begin
            out_resp  <= retire.valid ? retire.resp : 2'd0;
            out_data  <= (retire.valid && retire.resp == RESP_OK) ? retire.data : 32'd0;
            out_tag   <= retire.valid ? retire.tag : 2'd0;
            proto_err <= proto_d;
        end
    end

endmodule

// File: tb/tb_calc_port_responder.sv
// Bench for calc_port_responder. Directed requests push hand-computed
// responses, each tagged with the cycle in which it is due. A monitor
// compares every presented response against the queue.
module tb_calc_port_responder;

    localparam int LATENCY = 3;
    localparam int W = 68; // {due[31:0], resp[1:0], data[31:0], tag[1:0]}

    logic        c_clk = 1'b0;
    logic        reset;
    logic [3:0]  req_cmd_in;
    logic [31:0] req_data_in;
    logic [1:0]  req_tag_in;
    logic [1:0]  out_resp;
    logic [31:0] out_data;
    logic [1:0]  out_tag;
    logic        proto_err;
    logic        dbg_state;

    logic [W-1:0] exp_q[$];
    int           prot_q[$];
    int           cyc = 0;
    int           n_tests = 0;
    int           n_fail = 0;

    calc_port_responder #(.LATENCY(LATENCY)) dut (
        .c_clk      (c_clk),
        .reset      (reset),
        .req_cmd_in (req_cmd_in),
        .req_data_in(req_data_in),
        .req_tag_in (req_tag_in),
        .out_resp   (out_resp),
        .out_data   (out_data),
        .out_tag    (out_tag),
        .proto_err  (proto_err),
        .dbg_state  (dbg_state)
    );

    // Clock and cycle counter.
    always #5 c_clk = ~c_clk;
    always @(posedge c_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Driver: issue one request, starting in the current cycle. Called #1
    // after an edge. It returns #1 after the operand-2 edge, so consecutive
    // calls are back to back.
    task automatic send(input logic [3:0] cmd, input logic [31:0] op1, input logic [31:0] op2,
                        input logic [1:0] tag, input logic [3:0] op2_cmd, input bit exp_en,
                        input logic [1:0] e_resp, input logic [31:0] e_data);
        int e1;
        req_cmd_in  = cmd;
        req_data_in = op1;
        req_tag_in  = tag;
        @(posedge c_clk); #1;
        req_cmd_in  = op2_cmd;
        req_data_in = op2;
        req_tag_in  = 2'd0;
        @(posedge c_clk); #1;
        e1 = cyc;
        if (exp_en) exp_q.push_back({32'(e1 + LATENCY), e_resp, e_data, tag});
        if (op2_cmd != 4'd0) prot_q.push_back(e1);
        req_cmd_in  = 4'd0;
        req_data_in = 32'd0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge c_clk); #1;
        end
    endtask

    // Monitor: compares each presented response against the queue and
    // checks that the outputs are zero in every other cycle.
    always @(negedge c_clk) begin
        logic [W-1:0] e;
        if (out_resp != 2'd0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", {30'd0, out_resp}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("resp", {30'd0, out_resp}, {30'd0, e[35:34]});
                check("data", out_data, e[33:2]);
                check("tag", {30'd0, out_tag}, {30'd0, e[1:0]});
                check("resp_cycle", cyc, e[67:36]);
            end
        end else begin
            check("idle_data_tag", {out_data[31:2], out_data[1:0] | out_tag}, 32'd0);
        end
        if (proto_err) begin
            if (prot_q.size() == 0) check("unexpected_proto_err", 32'd1, 32'd0);
            else check("proto_err_cycle", cyc, prot_q.pop_front());
        end
    end

    // Stimulus sequence.
    initial begin
        reset       = 1'b0;
        req_cmd_in  = 4'd0;
        req_data_in = 32'd0;
        req_tag_in  = 2'd0;
        idle(3);
        check("reset_resp", {30'd0, out_resp}, 32'd0);
        check("reset_proto_err", {31'd0, proto_err}, 32'd0);
        check("reset_state", {31'd0, dbg_state}, 32'd0);
        reset = 1'b1;
        idle(2);

        send(4'd1, 32'd5, 32'd7, 2'd1, 4'd0, 1, 2'd1, 32'd12);
        idle(5);
        send(4'd1, 32'hFFFF_FFFF, 32'd1, 2'd2, 4'd0, 1, 2'd2, 32'd0);
        idle(5);
        send(4'd2, 32'd3, 32'd5, 2'd3, 4'd0, 1, 2'd2, 32'd0);
        send(4'd2, 32'd9, 32'd4, 2'd0, 4'd0, 1, 2'd1, 32'd5);
        idle(5);
        send(4'd5, 32'h1, 32'h1F, 2'd1, 4'd0, 1, 2'd1, 32'h8000_0000);
        send(4'd6, 32'h8000_0000, 32'h21, 2'd2, 4'd0, 1, 2'd1, 32'h4000_0000);
        idle(5);
        send(4'd3, 32'd7, 32'd8, 2'd3, 4'd0, 1, 2'd2, 32'd0);
        idle(5);
        // Back-to-back requests with tag 0: the second one conflicts.
        send(4'd1, 32'd1, 32'd1, 2'd0, 4'd0, 1, 2'd1, 32'd2);
        send(4'd1, 32'd2, 32'd2, 2'd0, 4'd0, 1, 2'd2, 32'd0);
        idle(6);
        // Protocol error: cmd 2 in the operand cycle; its data is operand 2.
        send(4'd1, 32'd10, 32'd3, 2'd1, 4'd2, 1, 2'd1, 32'd13);
        idle(6);
        // Reset one cycle after the operand-2 edge: the response is discarded.
        send(4'd1, 32'd20, 32'd30, 2'd0, 4'd0, 0, 2'd0, 32'd0);
        idle(1);
        reset = 1'b0;
        #1;
        check("midreset_resp", {30'd0, out_resp}, 32'd0);
        check("midreset_state", {31'd0, dbg_state}, 32'd0);
        idle(2);
        reset = 1'b1;
        idle(LATENCY + 4);
        // Tag 0 must be free again after the reset.
        send(4'd1, 32'd4, 32'd4, 2'd0, 4'd0, 1, 2'd1, 32'd8);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge c_clk);
        idle(2);
        check("pending_responses", exp_q.size(), 32'd0);
        check("pending_proto_err", prot_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/calc_port_responder.md
# calc_port_responder

Single-port responder for the calculator2 request/response protocol. It accepts a two-cycle command (command plus operand 1, then operand 2) with a 2-bit tag, computes the result, and returns a tagged one-cycle response after a fixed latency. It is the responder end of one calculator port. Four instances form a behavioural calculator that lets the bench run back-to-back against the DUT's port interface.

## Interface
- LATENCY, 3: cycles from the operand-2 edge to the response edge; legal range 1..8.
- c_clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_cmd_in  in  4  command; 0 = no-op; sampled only in IDLE.
- req_data_in  in  32  operand 1 in the command cycle, operand 2 in the following cycle.
- req_tag_in  in  2  request tag; sampled with the command.
- out_resp  out  2  0 = none, 1 = success, 2 = error; 3 is never driven.
- out_data  out  32  result; 0 whenever out_resp != 1.
- out_tag  out  2  tag of the responding request; 0 when out_resp = 0.
- proto_err  out  1  one-cycle pulse when a nonzero command arrives in the operand-2 cycle.

## Operation
- Capture FSM:
  - IDLE → OP2 on a nonzero req_cmd_in. Latch the command, operand 1 and the tag.
  - OP2 → IDLE unconditionally. Latch operand 2 and push one entry into the latency pipeline.
- A nonzero req_cmd_in in OP2 is ignored as a command. The cycle is still taken as operand 2, and proto_err is pulsed on the next edge.
- Commands:
  - 1 add: overflow past 32 bits → resp 2.
  - 2 sub: op2 > op1 → resp 2.
  - 5 shift left: op1 << op2[4:0].
  - 6 shift right: op1 >> op2[4:0], logical.
  - Shifts always give resp 1. op2[31:5] is ignored.
  - Any other nonzero command → resp 2, data 0.
- Tag conflict:
  - A 4-bit outstanding-tag bitmap is set on the OP2 edge and cleared on the response edge.
  - A command whose tag is already outstanding still completes, but with resp 2 and data 0.
  - It does not re-set the bit; the bit clears when the original request responds.
  - The conflict check is done at the OP2 edge, after any same-edge clear has been applied.
- The arithmetic result is computed combinationally at the OP2 edge and carried through the pipeline with resp and tag.
- The pipeline is a LATENCY-deep shift register of {valid, resp, data, tag}. Because a request takes at least two cycles, at most one response retires per cycle and no output queue is needed.
- Responses retire in request order.

## Timing
- Reset values: out_resp 0, out_data 0, out_tag 0, proto_err 0, FSM IDLE, pipeline valid bits 0, tag bitmap 0.
- Edge numbering: command sampled at edge E0, operand 2 at edge E1. out_resp/out_data/out_tag are registered and valid for exactly one cycle after edge E1+LATENCY.
- Maximum throughput is one request per 2 cycles, so back-to-back commands produce responses 2 cycles apart.
- Outputs return to 0/0/0 in every cycle without a retiring entry.
- Reset asserted mid-operation clears the FSM, pipeline and bitmap immediately. In-flight responses are discarded, and outputs are 0 while reset is low.
- After reset deasserts, the first edge may sample a command.
- proto_err is asserted one cycle after the offending edge, for one cycle.

## Test plan
- Add: cmd 1, op1 5, op2 7, tag 1, LATENCY 3 → resp 1, data 12, tag 1, in the single cycle after E1+3; outputs zero before and after.
- Add overflow: cmd 1, 0xFFFFFFFF + 1, tag 2 → resp 2, data 0, tag 2.
- Sub and shifts:
  - 3 − 5 → resp 2, data 0.
  - 9 − 4 → resp 1, data 5.
  - cmd 5, 0x1 with op2 0x1F → 0x80000000.
  - cmd 6, 0x80000000 with op2 0x21 → 0x40000000 (shift by 1).
- Invalid command and tag conflict: cmd 3 → resp 2, data 0. Two back-to-back cmd 1 requests both with tag 0 → first resp 1, second resp 2, responses 2 cycles apart.
- Protocol error: cmd 1 followed by cmd 2 in the operand cycle → proto_err pulses once; a single response is produced using the cmd 2 cycle's data as operand 2.
- Reset mid-flight: assert reset 1 cycle after the OP2 edge → no response ever emitted, all outputs 0; the next request after release responds normally with tag 0 usable.
